// File: rtl/power_rail_sequencer.sv
// Ordered up/down sequencing of board supply rails with latched PG fault supervision.
// Define PWR_SEQ_PG_FILTER_EN to require PG low across 2 ticks in ON before faulting.
module power_rail_sequencer #(
   parameter int NUM_RAILS     = 4,
   parameter int TICK_DIV      = 80000,
   parameter int STEP_MS       = 10,
   parameter int PG_TIMEOUT_MS = 50
) (
   input  logic                 clk_sys,
   input  logic                 RESET_N,
   input  logic                 powen_sys,
   input  logic [NUM_RAILS-1:0] rail_pg,
   input  logic                 fault_clr,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic                 all_up,
   output logic                 fault,
   output logic [2:0]           fault_rail,
   output logic [2:0]           seq_state
);

   localparam int DLY_MAX = (STEP_MS > PG_TIMEOUT_MS) ? STEP_MS : PG_TIMEOUT_MS;
   localparam int DW      = $clog2(DLY_MAX + 1);
   localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0]    LAST     = 3'(NUM_RAILS - 1);
   localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] STEP_C   = DW'(STEP_MS);
   localparam logic [DW-1:0] TO_C     = DW'(PG_TIMEOUT_MS);
   localparam logic [DW-1:0] DLY_C    = DW'(DLY_MAX);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RAMP_UP  = 3'd1,
      DWELL_UP = 3'd2,
      ON       = 3'd3,
      RAMP_DN  = 3'd4,
      FAULT    = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
   logic [DW-1:0]        dly_q, dly_d;
   logic [TW-1:0]        div_q, div_d;
   logic [NUM_RAILS-1:0] pg_m_q, pg_m_d;
   logic [NUM_RAILS-1:0] pg_s_q, pg_s_d;
   logic [2:0]           fault_rail_q, fault_rail_d;
   logic                 all_up_q, all_up_d;
   logic                 fault_q, fault_d;
   logic [NUM_RAILS-1:0] flt_q, flt_d;

   logic                 tick;
   logic [NUM_RAILS-1:0] cur;
   logic [NUM_RAILS-1:0] pg_bad;
   logic [2:0]           low_bad;

   assign tick = (div_q == DIV_LAST);
   assign cur  = NUM_RAILS'(1) << idx_q;

   always_comb begin
      pg_m_d = rail_pg;
      pg_s_d = pg_m_q;
      div_d  = tick ? '0 : div_q + TW'(1);
   end

`ifdef PWR_SEQ_PG_FILTER_EN
   // Each rail remembers a low sample at one tick; a second low tick faults.
   always_comb begin
      flt_d = '0;
      if (state_q == ON) begin
         for (int i = 0; i < NUM_RAILS; i++) begin
            if (pg_s_q[i]) flt_d[i] = 1'b0;
            else if (tick) flt_d[i] = 1'b1;
            else flt_d[i] = flt_q[i];
         end
      end
      pg_bad = ~pg_s_q & flt_q & {NUM_RAILS{tick}};
   end
`else
   always_comb begin
      flt_d  = '0;
      pg_bad = ~pg_s_q;
   end
`endif

   always_comb begin
      low_bad = '0;
      for (int i = NUM_RAILS - 1; i >= 0; i--) begin
         if (pg_bad[i]) low_bad = 3'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rail_en_d    = rail_en_q;
      fault_rail_d = fault_rail_q;
      unique case (state_q)
         IDLE: begin
            if (powen_sys) begin
               state_d   = RAMP_UP;
               idx_d     = '0;
               rail_en_d = NUM_RAILS'(1);
            end
         end
         RAMP_UP: begin
            if (dly_q == TO_C) begin
               state_d      = FAULT;
               fault_rail_d = idx_q;
               rail_en_d    = '0;
            end else if (!powen_sys) begin
               state_d   = RAMP_DN;
               rail_en_d = rail_en_q & ~cur;
            end else if (|(pg_s_q & cur)) begin
               state_d = DWELL_UP;
            end
         end
         DWELL_UP: begin
            if (!powen_sys) begin
               state_d   = RAMP_DN;
               rail_en_d = rail_en_q & ~cur;
            end else if (dly_q == STEP_C) begin
               if (idx_q == LAST) begin
                  state_d = ON;
               end else begin
                  state_d   = RAMP_UP;
                  idx_d     = idx_q + 3'd1;
                  rail_en_d = rail_en_q | (cur << 1);
               end
            end
         end
         ON: begin
            if (|pg_bad) begin
               state_d      = FAULT;
               fault_rail_d = low_bad;
               rail_en_d    = '0;
            end else if (!powen_sys) begin
               state_d   = RAMP_DN;
               idx_d     = LAST;
               rail_en_d = rail_en_q & ~(NUM_RAILS'(1) << LAST);
            end
         end
         RAMP_DN: begin
            if (dly_q == STEP_C) begin
               if (idx_q == 3'd0) begin
                  state_d = IDLE;
               end else begin
                  idx_d     = idx_q - 3'd1;
                  rail_en_d = rail_en_q & ~(cur >> 1);
               end
            end
         end
         FAULT: begin
            rail_en_d = '0;
            if (fault_clr && !powen_sys) begin
               state_d      = IDLE;
               idx_d        = '0;
               fault_rail_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            idx_d     = '0;
            rail_en_d = '0;
         end
      endcase
   end

   // Dwell/timeout counter restarts on any step; saturates in idle-like states.
   always_comb begin
      if (state_d != state_q || idx_d != idx_q) dly_d = '0;
      else if (tick && dly_q != DLY_C) dly_d = dly_q + DW'(1);
      else dly_d = dly_q;
      all_up_d = (state_d == ON);
      fault_d  = (state_d == FAULT);
   end

   always_ff @(posedge clk_sys) begin
      if (!RESET_N) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         rail_en_q    <= '0;
         dly_q        <= '0;
         div_q        <= '0;
         pg_m_q       <= '0;
         pg_s_q       <= '0;
         fault_rail_q <= '0;
         all_up_q     <= 1'b0;
         fault_q      <= 1'b0;
         flt_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rail_en_q    <= rail_en_d;
         dly_q        <= dly_d;
         div_q        <= div_d;
         pg_m_q       <= pg_m_d;
         pg_s_q       <= pg_s_d;
         fault_rail_q <= fault_rail_d;
         all_up_q     <= all_up_d;
         fault_q      <= fault_d;
         flt_q        <= flt_d;
      end
   end

   assign rail_en    = rail_en_q;
   assign all_up     = all_up_q;
   assign fault      = fault_q;
   assign fault_rail = fault_rail_q;
   assign seq_state  = state_q;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Directed/randomized bench for power_rail_sequencer; PG model follows enables by 3 cycles.
module tb_power_rail_sequencer;

   localparam int NR  = 4;
   localparam int DIV = 8;
   localparam int STP = 2;
   localparam int PTO = 5;

   // Timing windows from the tick rules: a step waits STP ticks after the
   // rail's PG is seen (3 cycles PG delay + 2 sync + 1 compare).
   localparam int UP_LO = (STP - 1) * DIV + 1;
   localparam int UP_HI = STP * DIV + 3 + 4;
   localparam int DN_LO = (STP - 1) * DIV + 1;
   localparam int DN_HI = STP * DIV + 2;
   localparam int TO_LO = (PTO - 1) * DIV + 1;
   localparam int TO_HI = PTO * DIV + 2;

   logic          clk_sys = 1'b0;
   logic          RESET_N;
   logic          powen_sys;
   logic [NR-1:0] rail_pg;
   logic          fault_clr;
   logic [NR-1:0] rail_en;
   logic          all_up;
   logic          fault;
   logic [2:0]    fault_rail;
   logic [2:0]    seq_state;

   logic [NR-1:0] pg_kill;
   logic [NR-1:0] d1 = '0, d2 = '0, d3 = '0;

   int checks   = 0;
   int failures = 0;

   power_rail_sequencer #(
      .NUM_RAILS    (NR),
      .TICK_DIV     (DIV),
      .STEP_MS      (STP),
      .PG_TIMEOUT_MS(PTO)
   ) dut (
      .clk_sys   (clk_sys),
      .RESET_N   (RESET_N),
      .powen_sys (powen_sys),
      .rail_pg   (rail_pg),
      .fault_clr (fault_clr),
      .rail_en   (rail_en),
      .all_up    (all_up),
      .fault     (fault),
      .fault_rail(fault_rail),
      .seq_state (seq_state)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      d1 <= rail_en;
      d2 <= d1;
      d3 <= d2;
   end

   assign rail_pg = d3 & ~pg_kill;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v, input int lo,
                          input int hi);
      checks++;
      assert (v >= lo && v <= hi) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic wait_en(input logic [NR-1:0] exp, input int budget,
                          output int n);
      n = 0;
      while (rail_en !== exp && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
   endtask

   task automatic wait_state(input logic [2:0] exp, input int budget,
                             output int n);
      n = 0;
      while (seq_state !== exp && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
   endtask

   task automatic power_up();
      int n;
      logic [NR-1:0] m;
      powen_sys = 1'b1;
      @(negedge clk_sys);
      chk("up_en0", rail_en, 4'b0001);
      chk("up_state1", seq_state, 3'd1);
      for (int k = 1; k < NR; k++) begin
         m = NR'((1 << (k + 1)) - 1);
         wait_en(m, 40, n);
         chk("up_en", rail_en, m);
         chk_rng("up_gap", n, UP_LO, UP_HI);
      end
      wait_state(3'd3, 40, n);
      chk("on_state", seq_state, 3'd3);
      chk("on_allup", all_up, 1'b1);
      chk("on_en", rail_en, 4'b1111);
      chk_rng("on_gap", n, UP_LO, UP_HI);
   endtask

   task automatic fault_release(input logic [2:0] rail);
      chk("flt_out", fault, 1'b1);
      chk("flt_rail", fault_rail, rail);
      chk("flt_en", rail_en, 4'b0000);
      chk("flt_allup", all_up, 1'b0);
      fault_clr = 1'b1;
      @(negedge clk_sys);
      fault_clr = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk("clr_ign_state", seq_state, 3'd5);
      chk("clr_ign_rail", fault_rail, rail);
      powen_sys = 1'b0;
      pg_kill   = '0;
      @(negedge clk_sys);
      fault_clr = 1'b1;
      @(negedge clk_sys);
      fault_clr = 1'b0;
      chk("clr_state", seq_state, 3'd0);
      chk("clr_fault", fault, 1'b0);
      repeat (5) @(negedge clk_sys);
   endtask

   initial begin
      int n;
      int lo;
      int t;
      logic [NR-1:0] m;

      RESET_N   = 1'b0;
      powen_sys = 1'b0;
      fault_clr = 1'b0;
      pg_kill   = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_en", rail_en, 4'b0000);
      chk("rst_allup", all_up, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_rail", fault_rail, 3'd0);
      chk("rst_state", seq_state, 3'd0);
      RESET_N = 1'b1;
      repeat ($urandom_range(1, 20)) @(negedge clk_sys);

      // Power-up, then brown-out on a random set of rails.
      power_up();
      repeat ($urandom_range(5, 30)) @(negedge clk_sys);
      m  = NR'($urandom_range(1, 15));
      lo = 0;
      for (int i = NR - 1; i >= 0; i--) if (m[i]) lo = i;
`ifdef PWR_SEQ_PG_FILTER_EN
      pg_kill = m;
      @(negedge clk_sys);
      pg_kill = '0;
      repeat (30) @(negedge clk_sys);
      chk("glitch_nofault", fault, 1'b0);
      chk("glitch_allup", all_up, 1'b1);
      pg_kill = m;
      repeat (20) @(negedge clk_sys);
      pg_kill = '0;
      wait_state(3'd5, 10, n);
`else
      pg_kill = m;
      @(negedge clk_sys);
      pg_kill = '0;
      wait_state(3'd5, 8, n);
`endif
      chk("bo_state", seq_state, 3'd5);
      fault_release(3'(lo));

      // Power-down; powen re-asserted mid ramp-down must not reverse it.
      power_up();
      repeat ($urandom_range(2, 20)) @(negedge clk_sys);
      powen_sys = 1'b0;
      @(negedge clk_sys);
      chk("dn_en3", rail_en, 4'b0111);
      chk("dn_allup", all_up, 1'b0);
      chk("dn_state", seq_state, 3'd4);
      wait_en(4'b0011, 30, n);
      chk("dn_en2", rail_en, 4'b0011);
      chk_rng("dn_gap2", n, DN_LO, DN_HI);
      powen_sys = 1'b1;
      wait_en(4'b0001, 30, n);
      chk("dn_en1", rail_en, 4'b0001);
      chk_rng("dn_gap1", n, DN_LO, DN_HI);
      wait_en(4'b0000, 30, n);
      chk("dn_en0", rail_en, 4'b0000);
      chk_rng("dn_gap0", n, DN_LO, DN_HI);
      wait_state(3'd0, 30, n);
      chk("dn_idle", seq_state, 3'd0);
      chk_rng("dn_gapi", n, DN_LO, DN_HI);
      @(negedge clk_sys);
      chk("restart_en", rail_en, 4'b0001);
      chk("restart_state", seq_state, 3'd1);
      // Abort in RAMP_UP of rail 0.
      powen_sys = 1'b0;
      @(negedge clk_sys);
      chk("ab0_en", rail_en, 4'b0000);
      chk("ab0_state", seq_state, 3'd4);
      wait_state(3'd0, 30, n);
      chk("ab0_idle", seq_state, 3'd0);
      repeat (3) @(negedge clk_sys);

      // PG timeout on a random rail.
      t       = $urandom_range(0, NR - 1);
      pg_kill = NR'(1 << t);
      m       = NR'((1 << (t + 1)) - 1);
      powen_sys = 1'b1;
      wait_en(m, 100, n);
      chk("to_en", rail_en, m);
      wait_state(3'd5, 60, n);
      chk("to_state", seq_state, 3'd5);
      chk_rng("to_time", n, TO_LO, TO_HI);
      fault_release(3'(t));

      // Abort while dwelling on rail 1.
      powen_sys = 1'b1;
      wait_en(4'b0011, 60, n);
      wait_state(3'd2, 20, n);
      chk("ab1_pre_state", seq_state, 3'd2);
      chk("ab1_pre_en", rail_en, 4'b0011);
      repeat ($urandom_range(0, 4)) @(negedge clk_sys);
      powen_sys = 1'b0;
      @(negedge clk_sys);
      chk("ab1_en", rail_en, 4'b0001);
      chk("ab1_state", seq_state, 3'd4);
      wait_en(4'b0000, 30, n);
      chk("ab1_en0", rail_en, 4'b0000);
      chk_rng("ab1_gap", n, DN_LO, DN_HI);
      wait_state(3'd0, 30, n);
      chk("ab1_idle", seq_state, 3'd0);

      // Reset while ON drops everything on the next edge.
      power_up();
      repeat ($urandom_range(1, 10)) @(negedge clk_sys);
      RESET_N = 1'b0;
      @(negedge clk_sys);
      chk("ron_en", rail_en, 4'b0000);
      chk("ron_state", seq_state, 3'd0);
      chk("ron_fault", fault, 1'b0);
      chk("ron_allup", all_up, 1'b0);
      RESET_N   = 1'b1;
      powen_sys = 1'b0;
      repeat (2) @(negedge clk_sys);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
